// File: rtl/alu_pkg.sv
// Shared encodings and sizing helpers for the multicycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADC  = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  // Iteration counter width; one spare bit so WIDTH-1 always fits.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit consumed per step.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod_nxt,
  output logic               o_last
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH:0]     w_sum;

  // Upper half accumulates the multiplicand; lower half holds the unconsumed
  // multiplier bits and shifts out one per step as product bits shift in.
  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                      (r_prod[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
  assign o_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
  assign o_last     = (r_cnt == CNT_W'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_prod  <= {{WIDTH{1'b0}}, i_b};
      r_cnt   <= '0;
    end else if (i_step) begin
      r_prod  <= o_prod_nxt;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multicycle ALU: single-cycle ADD/ADC/NAND/SUB, optional iterative MUL,
// registered result and flags, start/busy/done handshake.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             err
);

  state_e             r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero, r_carry, r_done, r_err, r_fwe;
  logic               w_load, w_step, w_last, w_mul_ok;
  logic [2*WIDTH-1:0] w_prod_nxt;
  logic               w_cin;
  logic [WIDTH:0]     w_sum, w_diff;
  logic [WIDTH-1:0]   w_sc_res;
  logic               w_sc_c, w_sc_cwr, w_sc_ok;

  assign w_mul_ok = (MUL_EN != 0) && (op == OP_MUL);

  generate
    if (MUL_EN != 0) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_a        (a),
        .i_b        (b),
        .o_prod_nxt (w_prod_nxt),
        .o_last     (w_last)
      );
    end else begin : g_nomul
      assign w_prod_nxt = '0;
      assign w_last     = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    if (r_state == S_IDLE) begin
      if (start && w_mul_ok) begin
        w_state_nxt = S_MUL;
        w_load      = 1'b1;
      end
    end else begin
      w_step = 1'b1;
      if (w_last) w_state_nxt = S_IDLE;
    end
  end

  // ADC uses the flag as it stands at the accepting edge.
  assign w_cin  = (op == OP_ADC) & r_carry;
  assign w_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, w_cin};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    w_sc_res = '0;
    w_sc_c   = 1'b0;
    w_sc_cwr = 1'b0;
    w_sc_ok  = 1'b1;
    case (op)
      OP_ADD, OP_ADC: begin
        w_sc_res = w_sum[WIDTH-1:0];
        w_sc_c   = w_sum[WIDTH];
        w_sc_cwr = 1'b1;
      end
      OP_NAND: w_sc_res = ~(a & b);
      OP_SUB: begin
        w_sc_res = w_diff[WIDTH-1:0];
        w_sc_c   = w_diff[WIDTH];
        w_sc_cwr = 1'b1;
      end
      default: w_sc_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_fwe    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      if (r_state == S_IDLE) begin
        if (start) begin
          if (w_mul_ok) begin
            r_fwe <= flag_we;
          end else if (w_sc_ok) begin
            r_result <= w_sc_res;
            r_done   <= 1'b1;
            if (flag_we) begin
              r_zero <= (w_sc_res == '0);
              if (w_sc_cwr) r_carry <= w_sc_c;
            end
          end else begin
            r_result <= '0;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
          end
        end
      end else if (w_last) begin
        r_result <= w_prod_nxt[WIDTH-1:0];
        r_done   <= 1'b1;
        if (r_fwe) begin
          r_zero  <= (w_prod_nxt[WIDTH-1:0] == '0);
          r_carry <= |w_prod_nxt[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

  assign busy   = (r_state == S_MUL);
  assign done   = r_done;
  assign result = r_result;
  assign zero   = r_zero;
  assign carry  = r_carry;
  assign err    = r_err;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=16, with a MUL_EN=0 copy on the same inputs.
module tb_alu_mc;
  import alu_pkg::*;

  logic        clk, rst, start, flag_we;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic        busy, done, zero, carry, err;
  logic [15:0] result;
  logic        busy0, done0, zero0, carry0, err0;
  logic [15:0] result0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        seen;

  alu_mc #(.WIDTH(16), .MUL_EN(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flag_we(flag_we), .busy(busy), .done(done), .result(result),
    .zero(zero), .carry(carry), .err(err)
  );

  alu_mc #(.WIDTH(16), .MUL_EN(0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flag_we(flag_we), .busy(busy0), .done(done0), .result(result0),
    .zero(zero0), .carry(carry0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request for a single edge; returns 1 time unit after that edge.
  task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic we);
    @(negedge clk);
    op = o; a = x; b = y; flag_we = we; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic d, input logic e, input logic [15:0] r,
                         input logic z, input logic c, input logic bz);
    chk({tag, ".done"},   done,   d);
    chk({tag, ".err"},    err,    e);
    chk({tag, ".result"}, result, r);
    chk({tag, ".zero"},   zero,   z);
    chk({tag, ".carry"},  carry,  c);
    chk({tag, ".busy"},   busy,   bz);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = OP_ADD; a = '0; b = '0; flag_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset wins over a simultaneous start
    @(negedge clk);
    op = OP_ADD; a = 16'hFFFF; b = 16'h0001; flag_we = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_out("rst_start", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;

    // 1: ADD wraps to zero with carry
    do_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
    chk_out("add", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    // 2: back-to-back ADC consumes carry=1; NAND leaves carry alone
    do_op(OP_ADC, 16'h0001, 16'h0001, 1'b1);
    chk_out("adc", 1'b1, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    do_op(OP_NAND, 16'hFFFF, 16'hFFFF, 1'b1);
    chk_out("nand", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(OP_NAND, 16'h0F0F, 16'h00FF, 1'b0);
    chk_out("nand_nowe", 1'b1, 1'b0, 16'hFFF0, 1'b1, 1'b0, 1'b0);

    // 3: SUB with and without flag write
    do_op(OP_SUB, 16'h0003, 16'h0005, 1'b0);
    chk_out("sub_nowe", 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    do_op(OP_SUB, 16'h0003, 16'h0005, 1'b1);
    chk_out("sub_we", 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b1, 1'b0);
    do_op(OP_SUB, 16'h0005, 16'h0005, 1'b1);
    chk_out("sub_eq", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse", done, 1'b0);

    // 4: MUL 0x100*0x100 = 0x10000, with an ignored start mid-flight
    do_op(OP_MUL, 16'h0100, 16'h0100, 1'b1);
    chk("mul0.busy_e0", busy, 1'b1);
    chk("mul0.done_e0", done, 1'b0);
    op = OP_ADD; a = 16'h0001; b = 16'h0001; flag_we = 1'b1; start = 1'b1;
    for (int k = 1; k < 16; k++) begin
      @(posedge clk); #1;
      chk($sformatf("mul0.busy_e%0d", k), busy, 1'b1);
      chk($sformatf("mul0.done_e%0d", k), done, 1'b0);
      if (k == 3) start = 1'b0;
    end
    @(posedge clk); #1;
    chk_out("mul0", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);

    do_op(OP_MUL, 16'h0003, 16'h0005, 1'b1);
    repeat (16) @(posedge clk);
    #1;
    chk_out("mul1", 1'b1, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0);

    // 5: reset sampled on the 5th iteration edge aborts the MUL
    do_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
    do_op(OP_MUL, 16'h0003, 16'h0005, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_out("abort", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort.no_done", seen, 1'b0);

    // 6: illegal op leaves flags alone
    do_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b1);
    chk_out("pre_ill", 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    do_op(OP_ADD, 16'h1234, 16'h0001, 1'b0);
    do_op(3'b111, 16'h1234, 16'h5678, 1'b1);
    chk_out("ill111", 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    do_op(OP_ADD, 16'h0002, 16'h0003, 1'b0);
    chk_out("post_ill", 1'b1, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b0);

    // MUL_EN=0 copy treats MUL as illegal
    do_op(OP_MUL, 16'h0003, 16'h0005, 1'b1);
    chk("nomul.done",   done0,   1'b1);
    chk("nomul.err",    err0,    1'b1);
    chk("nomul.result", result0, 16'h0000);
    chk("nomul.zero",   zero0,   1'b1);
    chk("nomul.carry",  carry0,  1'b1);
    chk("nomul.busy",   busy0,   1'b0);
    chk("mulen.busy",   busy,    1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multicycle ALU for the multicycle processor datapath. Supports ADD, ADC, NAND, SUB and an optional iterative shift-add MUL. Holds registered result and carry/zero flag state. Uses a start/busy/done handshake so the control FSM can wait on variable-latency operations.

## Interface
- `WIDTH`, 16: operand and result width in bits (≥4).
- `MUL_EN`, 1: 1 enables the MUL op; 0 makes op 3'b100 illegal.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request an operation; sampled only when `busy`=0.
- `op` in 3: 000 ADD, 001 ADC, 010 NAND, 011 SUB, 100 MUL, 101–111 illegal.
- `a`, `b` in WIDTH: operands; sampled with `start`.
- `flag_we` in 1: sampled with `start`; 1 means the op updates the flags it defines.
- `busy` out 1: operation in flight; `start` is ignored while high.
- `done` out 1: one-cycle pulse; `result`/`err` are valid in that cycle.
- `result` out WIDTH: registered result; holds until the next `done`.
- `zero` out 1: registered zero flag.
- `carry` out 1: registered carry/borrow flag.
- `err` out 1: high with `done` when the accepted op was illegal.

## Operation
- States:
  - IDLE: accepts `start`.
  - MUL: iterates.
- Single-cycle ops are computed from the live inputs and registered at the accepting edge.
- Arithmetic is unsigned modulo 2^WIDTH, with an internal (WIDTH+1)-bit sum.
- ADD: `result` = a+b; carry = bit WIDTH of the sum.
- ADC: `result` = a+b+`carry`, using the flag value at the accepting edge. Carry out is as for ADD.
- NAND: `result` = ~(a&b). `carry` is never modified by NAND.
- SUB: `result` = a−b; carry = borrow (1 iff a<b unsigned).
- MUL: shift-add, one bit of `b` per cycle, WIDTH iterations, 2·WIDTH-bit accumulator.
  - `result` = low WIDTH bits.
  - carry = 1 iff the high WIDTH bits are nonzero.
- Flags are written only at the `done` edge and only if the captured `flag_we`=1.
  - `zero` = (result==0) for every legal op.
  - `carry` per op as above; NAND leaves it unchanged.
- Illegal op:
  - `done`=1 and `err`=1 next cycle; `result`=0.
  - Flags unchanged regardless of `flag_we`.
- `start` while `busy`=1 is ignored: no queueing, no effect on the in-flight op.
- Reset values:
  - `result`=0, `zero`=0, `carry`=0.
  - `busy`=0, `done`=0, `err`=0.
  - State IDLE; iteration counter 0.

## Timing
- Single-cycle op (legal or illegal): `start` sampled at edge E0; `done` high for the cycle after E0. `busy` never rises.
- MUL:
  - `start` sampled at E0; iterations on edges E1..E(WIDTH−1); final accumulate plus `result`/flag write at E(WIDTH).
  - `busy` high from E0 to E(WIDTH).
  - `done` high for the cycle after E(WIDTH), i.e. latency WIDTH; `busy` falls on the same edge `done` rises.
- Back-to-back: `start` is accepted in the cycle `done` is high (since `busy`=0). Single-cycle ops therefore sustain one per cycle with `done` continuously high.
- Reset mid-MUL: the op is aborted at the next edge, outputs return to reset values, and no `done` is produced.
- `rst` and `start` in the same cycle: reset wins; the op is dropped.
- ADC immediately after a flag-writing op sees the updated `carry`; the flag register is written at the edge before the new `start` is sampled.

## Structure
- Package `alu_pkg`:
  - op encodings (`OP_ADD`…`OP_MUL`);
  - state enum (`S_IDLE`, `S_MUL`);
  - helper width constant for the counter, $clog2(WIDTH)+1.
- Sub-module `alu_mul_seq`:
  - iterative shift-add multiplier with `load`/`step` controls, a 2·WIDTH product register and a `last` indicator.
  - Instantiated only under `MUL_EN`.
- Top level holds the FSM, the single-cycle datapath, and the result/flag registers.

## Test plan
All at WIDTH=16.
1. Reset then ADD a=0xFFFF, b=0x0001, flag_we=1 → next cycle `done`=1, `result`=0x0000, `carry`=1, `zero`=1, `busy` stays 0.
2. Immediately ADC a=0x0001, b=0x0001, flag_we=1 → `result`=0x0003, `carry`=0, `zero`=0. Then NAND 0xFFFF,0xFFFF, flag_we=1 → `result`=0x0000, `zero`=1, `carry` stays 0.
3. SUB a=0x0003, b=0x0005, flag_we=0 → `result`=0xFFFE, flags unchanged. Repeat with flag_we=1 → `carry`=1, `zero`=0.
4. MUL a=0x0100, b=0x0100, flag_we=1 → `busy` for 16 cycles, then `done` 16 cycles after the start edge, `result`=0x0000, `carry`=1, `zero`=1. A `start` issued mid-operation is ignored; a second MUL 0x0003×0x0005 → `result`=0x000F, `carry`=0.
5. `rst` asserted on the 5th MUL iteration → all outputs 0 next cycle, no `done` ever appears for that op.
6. Illegal op 3'b111 with flag_we=1 → next cycle `done`=1, `err`=1, `result`=0, flags unchanged. With MUL_EN=0, op 3'b100 → same `err` behaviour.
